// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode/funct3 encodings and load/store unit types shared by the MEM stage.
package riscv_pkg;
  typedef enum logic [6:0] {
    LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
    BTYPE = 7'b1100011, LTYPE = 7'b0000011, STYPE = 7'b0100011,
    ITYPE = 7'b0010011, RTYPE = 7'b0110011
  } op_code;
  typedef enum logic [2:0] {LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101} l_func;
  typedef enum logic [2:0] {SB = 3'b000, SH = 3'b001, SW = 3'b010} s_func;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  // Unshifted byte-enable mask for an access; unknown funct3 falls back to a full word.
  function automatic logic [3:0] be_base(input logic [2:0] f3, input logic store);
    return store ? (f3 == SB ? BE_BYTE : f3 == SH ? BE_HALF : BE_WORD)
                 : (f3 == LB || f3 == LBU ? BE_BYTE : f3 == LH || f3 == LHU ? BE_HALF : BE_WORD);
  endfunction
endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: word-wide data-memory request/response port.
interface mem_stage_lsu_if #(parameter int XLEN = 32);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                 input dmem_gnt, dmem_rvalid, dmem_rdata);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/load_extend.sv
// load_extend: selects the byte/halfword lane of a read word and sign/zero-extends it.
module load_extend import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      lane_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[8*lane_i +: 8];
    h = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = funct3_i == LB  ? {{(XLEN-8){b[7]}}, b} :
             funct3_i == LBU ? {{(XLEN-8){1'b0}}, b} :
             funct3_i == LH  ? {{(XLEN-16){h[15]}}, h} :
             funct3_i == LHU ? {{(XLEN-16){1'b0}}, h} : rdata_i;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I MEM stage; issues data-memory requests, stalls while they are
// outstanding, and produces the MEM/WB result (load data or passed-through ALU result).
module mem_stage_lsu import riscv_pkg::*; #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  input  logic [6:0]              ex_opcode,
  input  logic [2:0]              ex_funct3,
  input  logic [XLEN-1:0]         ex_alu_result,
  input  logic [XLEN-1:0]         ex_store_data,
  input  logic [4:0]              ex_rd,
  input  logic                    flush,
  mem_stage_lsu_if.master         dmem,
  output logic                    mem_stall,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [XLEN-1:0]         wb_data,
  output logic                    misalign,
  output logic                    bus_err
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, sdata_q, wb_data_q, cur_addr, cur_sdata, ld_data;
  logic [2:0]      f3_q, cur_f3;
  logic [4:0]      rd_q, wb_rd_q, cur_rd;
  logic [3:0]      base;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic st_q, kill_q, kill_d, wb_valid_q, misalign_q, bus_err_q;
  logic idle, mem_op, ex_go, cur_st, mis, issue, req_phase, withdraw, granted;
  logic resp, done, timeout, discard, pass, req;

  // In IDLE the request is built straight from EX/MEM so it can go out the same cycle;
  // afterwards the captured copy keeps every request field stable.
  always_comb begin
    idle      = state_q == IDLE;
    mem_op    = ex_opcode == LTYPE || ex_opcode == STYPE;
    ex_go     = ex_valid && !flush;
    cur_addr  = idle ? ex_alu_result : addr_q;
    cur_sdata = idle ? ex_store_data : sdata_q;
    cur_f3    = idle ? ex_funct3 : f3_q;
    cur_rd    = idle ? ex_rd : rd_q;
    cur_st    = idle ? ex_opcode == STYPE : st_q;
    base      = be_base(cur_f3, cur_st);
    mis       = base == BE_HALF ? cur_addr[0] : (base == BE_WORD && cur_addr[1:0] != 2'b00);
    issue     = idle && ex_go && mem_op && !mis;
    withdraw  = state_q == REQ && flush;
    req_phase = issue || (state_q == REQ && !flush);
    granted   = req_phase && dmem.dmem_gnt;
    resp      = dmem.dmem_rvalid && (state_q == WAIT || (granted && !cur_st));
    done      = (granted && cur_st) || resp;
    timeout   = !idle && !done && !withdraw && cnt_q == CW'(MEM_TIMEOUT - 1);
    discard   = state_q == WAIT && (kill_q || flush);
    pass      = idle && ex_go && !mem_op;
  end

  load_extend #(.XLEN(XLEN)) u_ext (
    .funct3_i(cur_f3), .lane_i(cur_addr[1:0]), .rdata_i(dmem.dmem_rdata), .data_o(ld_data)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = (!(req_phase || state_q == WAIT) || done || timeout) ? IDLE :
              (state_q == WAIT || granted) ? WAIT : REQ;
    cnt_d   = (idle || state_d == IDLE) ? '0 : cnt_q + 1'b1;
    kill_d  = state_q == WAIT && (kill_q || flush);
  end

  always_comb begin
    req             = rst_n && req_phase;
    dmem.dmem_req   = req;
    dmem.dmem_we    = req && cur_st;
    dmem.dmem_addr  = req ? {cur_addr[XLEN-1:2], 2'b00} : '0;
    dmem.dmem_be    = req ? base << cur_addr[1:0] : '0;
    dmem.dmem_wdata = !req ? '0 : base == BE_BYTE ? {(XLEN/8){cur_sdata[7:0]}} :
                      base == BE_HALF ? {(XLEN/16){cur_sdata[15:0]}} : cur_sdata;
    mem_stall       = rst_n && (issue || !idle);
    wb_valid        = wb_valid_q;
    wb_rd           = wb_rd_q;
    wb_data         = wb_data_q;
    misalign        = misalign_q;
    bus_err         = bus_err_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q     <= '0;
      sdata_q    <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      st_q       <= 1'b0;
      kill_q     <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      if (issue) begin
        addr_q  <= ex_alu_result;
        sdata_q <= ex_store_data;
        f3_q    <= ex_funct3;
        rd_q    <= ex_rd;
        st_q    <= ex_opcode == STYPE;
      end
      kill_q     <= kill_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= pass || (granted && cur_st) || (resp && !discard);
      wb_rd_q    <= pass ? ex_rd : (resp && !discard) ? cur_rd : '0;
      wb_data_q  <= pass ? ex_alu_result : (resp && !discard) ? ld_data : '0;
      misalign_q <= idle && ex_go && mem_op && mis;
      bus_err_q  <= timeout;
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table-driven checks of the MEM-stage LSU with a write-back scoreboard.
module tb_mem_stage_lsu;
  localparam logic [6:0] LT = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;

  typedef struct {
    string name; logic [6:0] op; logic [2:0] f3; logic [31:0] addr, sdata, rdata; logic [4:0] rd;
    int gnt_at, rv_at, fl_at;
    logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata; logic e_we;
    int e_req, e_stall, e_mis, e_err; logic e_wbv; logic [4:0] e_rd; logic [31:0] e_data;
  } vec_t;
  typedef struct {logic [4:0] rd; logic [31:0] data; logic chk_data; string nm;} wb_t;

  logic clk = 0, rst_n = 0, ex_valid = 0, flush = 0;
  logic [6:0] ex_opcode = 0;
  logic [2:0] ex_funct3 = 0;
  logic [31:0] ex_alu_result = 0, ex_store_data = 0;
  logic [4:0] ex_rd = 0;
  logic mem_stall, wb_valid, misalign, bus_err;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  int n_chk = 0, n_fail = 0;
  wb_t sb[$];
  vec_t v[19];

  mem_stage_lsu_if #(.XLEN(32)) bus();
  mem_stage_lsu #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd), .flush(flush),
    .dmem(bus), .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (wb_valid) begin
      wb_t e;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_wb: got wb_valid=1 rd=%0d data=%h, want wb_valid=0", wb_rd, wb_data);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_wb_rd"}, 32'(wb_rd), 32'(e.rd));
        if (e.chk_data) chk({e.nm, "_wb_data"}, wb_data, e.data);
      end
    end

  task automatic run(input vec_t t);
    int stall = 0, mis = 0, err = 0, reqs = 0;
    ex_opcode = t.op; ex_funct3 = t.f3; ex_alu_result = t.addr; ex_store_data = t.sdata; ex_rd = t.rd;
    if (t.e_wbv) sb.push_back('{t.e_rd, t.e_data, !t.e_we, t.name});
    for (int c = 0; c < 10; c++) begin
      ex_valid = c == 0;
      bus.dmem_gnt = c == t.gnt_at;
      bus.dmem_rvalid = c == t.rv_at;
      bus.dmem_rdata = t.rdata;
      flush = c == t.fl_at;
      @(negedge clk);
      stall += int'(mem_stall);
      mis += int'(misalign);
      err += int'(bus_err);
      if (bus.dmem_req) begin
        reqs++;
        chk({t.name, "_addr"}, bus.dmem_addr, t.e_addr);
        chk({t.name, "_be"}, 32'(bus.dmem_be), 32'(t.e_be));
        chk({t.name, "_we"}, 32'(bus.dmem_we), 32'(t.e_we));
        if (t.e_we) chk({t.name, "_wdata"}, bus.dmem_wdata, t.e_wdata);
      end
      @(posedge clk); #1;
    end
    ex_valid = 0; flush = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
    chk({t.name, "_req_cycles"}, reqs, t.e_req);
    chk({t.name, "_stall_cycles"}, stall, t.e_stall);
    chk({t.name, "_misalign"}, mis, t.e_mis);
    chk({t.name, "_bus_err"}, err, t.e_err);
  endtask

  initial begin
    bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
    v[0]  = '{"add", RT, 0, 32'h1234, 0, 0, 5, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234};
    v[1]  = '{"add_flush", RT, 0, 32'hDEADBEEF, 0, 0, 31, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[2]  = '{"add_r31", RT, 0, 32'hDEADBEEF, 0, 0, 31, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 32'hDEADBEEF};
    v[3]  = '{"sb", ST, 0, 32'h103, 32'hAABBCCDD, 0, 7, 0, -1, -1, 32'h100, 4'b1000, 32'hDDDDDDDD, 1, 1, 1, 0, 0, 1, 0, 0};
    v[4]  = '{"sh", ST, 1, 32'h102, 32'h1234ABCD, 0, 8, 1, -1, -1, 32'h100, 4'b1100, 32'hABCDABCD, 1, 2, 2, 0, 0, 1, 0, 0};
    v[5]  = '{"sw", ST, 2, 32'h104, 32'hCAFEF00D, 0, 9, 0, -1, -1, 32'h104, 4'b1111, 32'hCAFEF00D, 1, 1, 1, 0, 0, 1, 0, 0};
    v[6]  = '{"lb", LT, 0, 32'h202, 0, 32'h00800000, 10, 0, 3, -1, 32'h200, 4'b0100, 0, 0, 1, 4, 0, 0, 1, 10, 32'hFFFFFF80};
    v[7]  = '{"lbu", LT, 4, 32'h202, 0, 32'h00800000, 10, 0, 3, -1, 32'h200, 4'b0100, 0, 0, 1, 4, 0, 0, 1, 10, 32'h00000080};
    v[8]  = '{"lh", LT, 1, 32'h202, 0, 32'h80010000, 11, 0, 0, -1, 32'h200, 4'b1100, 0, 0, 1, 1, 0, 0, 1, 11, 32'hFFFF8001};
    v[9]  = '{"lhu", LT, 5, 32'h202, 0, 32'h80010000, 11, 0, 0, -1, 32'h200, 4'b1100, 0, 0, 1, 1, 0, 0, 1, 11, 32'h00008001};
    v[10] = '{"lb_lane1", LT, 0, 32'h201, 0, 32'h0000FF00, 12, 0, 1, -1, 32'h200, 4'b0010, 0, 0, 1, 2, 0, 0, 1, 12, 32'hFFFFFFFF};
    v[11] = '{"lw", LT, 2, 32'h208, 0, 32'h12345678, 13, 1, 2, -1, 32'h208, 4'b1111, 0, 0, 2, 3, 0, 0, 1, 13, 32'h12345678};
    v[12] = '{"lh_mis", LT, 1, 32'h201, 0, 0, 14, -1, -1, -1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    v[13] = '{"lw_mis", LT, 2, 32'h206, 0, 0, 14, -1, -1, -1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    v[14] = '{"sw_mis", ST, 2, 32'h101, 32'h1, 0, 14, -1, -1, -1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    v[15] = '{"lw_flush_wait", LT, 2, 32'h300, 0, 32'h11111111, 15, 2, 4, 3, 32'h300, 4'b1111, 0, 0, 3, 5, 0, 0, 0, 0, 0};
    v[16] = '{"lw_flush_req", LT, 2, 32'h304, 0, 0, 16, 3, -1, 1, 32'h304, 4'b1111, 0, 0, 1, 2, 0, 0, 0, 0, 0};
    v[17] = '{"lw_timeout", LT, 2, 32'h308, 0, 0, 17, 0, -1, -1, 32'h308, 4'b1111, 0, 0, 1, 5, 0, 1, 0, 0, 0};
    v[18] = '{"lw_f3_undef", LT, 3, 32'h20C, 0, 32'h80000001, 18, 0, 0, -1, 32'h20C, 4'b1111, 0, 0, 1, 1, 0, 0, 1, 18, 32'h80000001};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.dmem_req), 0);
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_pulses", 32'({misalign, bus_err}), 0);
    @(posedge clk); #1 rst_n = 1;

    foreach (v[i]) run(v[i]);

    // Reset while a load waits for its response; the late response must be ignored.
    ex_opcode = LT; ex_funct3 = 3'd2; ex_alu_result = 32'h400; ex_rd = 5'd9;
    ex_valid = 1; bus.dmem_gnt = 1;
    @(posedge clk); #1 ex_valid = 0; bus.dmem_gnt = 0;
    @(negedge clk);
    chk("mw_stall_before_rst", 32'(mem_stall), 1);
    #1 rst_n = 0;
    #1;
    chk("mw_rst_stall", 32'(mem_stall), 0);
    chk("mw_rst_req", 32'(bus.dmem_req), 0);
    chk("mw_rst_addr", bus.dmem_addr, 0);
    chk("mw_rst_be", 32'(bus.dmem_be), 0);
    chk("mw_rst_wb_valid", 32'(wb_valid), 0);
    chk("mw_rst_wb_rd", 32'(wb_rd), 0);
    chk("mw_rst_pulses", 32'({misalign, bus_err}), 0);
    @(posedge clk); #1 rst_n = 1; bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h55;
    @(negedge clk);
    chk("mw_after_stall", 32'(mem_stall), 0);
    @(posedge clk); #1 bus.dmem_rvalid = 0;
    repeat (3) @(negedge clk);
    chk("mw_after_wb_valid", 32'(wb_valid), 0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
